key_code_decoder: RTL and testbench

KEY_CODE_DECODER -- requirements
Module: key_code_decoder

---
 rtl/key_code_decoder.sv | 165 ++++++++++++++++
 tb/tb_key_code_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_code_decoder.sv
// Queues 4-bit key codes and shows each one on an active-low one-hot key
// pattern for HOLD_CYCLES cycles, followed by GAP_CYCLES blank cycles.
module key_code_decoder #(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] code,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] key_n,
  output logic       busy,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [4:0]    DEPTH_C   = 5'(FIFO_DEPTH);
  localparam logic [15:0]   HOLD_LOAD = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]   GAP_LOAD  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
  localparam bit            HAS_GAP   = (GAP_CYCLES > 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [7:0]    key_n_q, key_n_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [2:0]    mem_q [FIFO_DEPTH];

  logic       legal;
  logic       accept;
  logic       push;
  logic       pop;
  logic [3:0] idx_full;
  logic [2:0] key_idx;
  logic [2:0] head;

  // Legal codes run 1110 (key0) down to 0111 (key7), so key = 14 - code.
  assign legal      = (code >= 4'd7) && (code <= 4'd14);
  assign idx_full   = 4'd14 - code;
  assign key_idx    = idx_full[2:0];
  assign code_ready = (cnt_q < DEPTH_C);
  assign accept     = code_valid && code_ready;
  assign push       = accept && legal;
  assign pop        = (state_q == IDLE) && (cnt_q != 5'd0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    key_n_d   = key_n_q;
    busy_d    = busy_q;
    err_d     = accept && !legal;
    err_cnt_d = err_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;

    if (accept && !legal && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      IDLE: begin
        key_n_d = 8'hFF;
        busy_d  = 1'b0;
        if (pop) begin
          key_n_d = ~(8'd1 << head);
          timer_d = HOLD_LOAD;
          busy_d  = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (timer_q == 16'd0) begin
          key_n_d = 8'hFF;
          if (HAS_GAP) begin
            timer_d = GAP_LOAD;
            state_d = GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      GAP: begin
        key_n_d = 8'hFF;
        if (timer_q == 16'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: begin
        key_n_d = 8'hFF;
        busy_d  = 1'b0;
        timer_d = 16'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      timer_q   <= 16'd0;
      key_n_q   <= 8'hFF;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      key_n_q   <= key_n_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[wr_ptr_q] <= key_idx;
    end
  end

  assign key_n   = key_n_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_key_code_decoder.sv
// Directed and random stimulus for key_code_decoder, checked against a
// queue-based model of the display slot timeline.
module tb_key_code_decoder;

  localparam int HOLD  = 4;
  localparam int GAPC  = 2;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [3:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] key_n;
  logic       busy;
  logic       err;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  // Model: accepted keys in order, plus the position inside the current
  // display slot (-1 = idle, 0..HOLD-1 lit, HOLD..HOLD+GAPC-1 blank).
  int   mQueue[$];
  int   mSlot   = -1;
  int   mKey    = 0;
  logic mErr    = 1'b0;
  int   mErrCnt = 0;
  bit   modelOn = 1'b0;
  bit   sawNotReady;

  key_code_decoder #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .code      (code),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .key_n     (key_n),
    .busy      (busy),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int codeToKey(input logic [3:0] c);
    case (c)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1100: return 2;
      4'b1011: return 3;
      4'b1010: return 4;
      4'b1001: return 5;
      4'b1000: return 6;
      4'b0111: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] expKey;
    expKey = (mSlot >= 0 && mSlot < HOLD) ? ~(8'd1 << mKey) : 8'hFF;
    checkValue("key_n", key_n, expKey);
    checkValue("busy", {7'd0, busy}, {7'd0, (mSlot >= 0)});
    checkValue("err", {7'd0, err}, {7'd0, mErr});
    checkValue("err_cnt", err_cnt, 8'(mErrCnt));
  endtask

  // Drive one cycle of inputs, check ready, clock, advance model, check outputs.
  task automatic applyStimulus(input logic rstN, input logic vld, input logic [3:0] c,
                               output logic took);
    logic mReady;
    reset      = rstN;
    code_valid = vld;
    code       = c;
    mReady     = (mQueue.size() < DEPTH);
    #1;
    if (modelOn) begin
      checkValue("code_ready", {7'd0, code_ready}, {7'd0, mReady});
      if (!code_ready) sawNotReady = 1'b1;
    end
    took = rstN && vld && mReady;
    @(posedge clk);
    if (!rstN) begin
      mQueue.delete();
      mSlot   = -1;
      mErr    = 1'b0;
      mErrCnt = 0;
      modelOn = 1'b1;
    end else begin
      if (mSlot < 0) begin
        if (mQueue.size() > 0) begin
          mKey  = mQueue.pop_front();
          mSlot = 0;
        end
      end else begin
        mSlot++;
        if (mSlot == HOLD + GAPC) mSlot = -1;
      end
      mErr = 1'b0;
      if (took) begin
        if (codeToKey(c) >= 0) begin
          mQueue.push_back(codeToKey(c));
        end else begin
          mErr = 1'b1;
          if (mErrCnt < 255) mErrCnt++;
        end
      end
    end
    #1;
    if (modelOn) checkOutput();
  endtask

  task automatic idleCycles(input int n);
    logic t;
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'd0, t);
  endtask

  initial begin
    logic       took;
    logic [3:0] six [6];
    int         idx;
    int         budget;

    reset      = 1'b0;
    code_valid = 1'b0;
    code       = 4'd0;
    @(posedge clk);
    #1;

    $display("[TB] reset with code_valid high");
    applyStimulus(1'b0, 1'b1, 4'b1110, took);
    applyStimulus(1'b0, 1'b1, 4'b1011, took);
    checkValue("reset_key_n", key_n, 8'hFF);
    idleCycles(3);

    $display("[TB] single code 1011");
    applyStimulus(1'b1, 1'b1, 4'b1011, took);
    applyStimulus(1'b1, 1'b0, 4'd0, took);
    checkValue("single_key3", key_n, 8'b1111_0111);
    idleCycles(10);

    $display("[TB] back-to-back 1110, 0111");
    applyStimulus(1'b1, 1'b1, 4'b1110, took);
    applyStimulus(1'b1, 1'b1, 4'b0111, took);
    idleCycles(20);

    $display("[TB] six codes while showing");
    six[0] = 4'b1101; six[1] = 4'b1100; six[2] = 4'b1010;
    six[3] = 4'b1001; six[4] = 4'b1000; six[5] = 4'b0111;
    applyStimulus(1'b1, 1'b1, 4'b1110, took);
    applyStimulus(1'b1, 1'b0, 4'd0, took);
    sawNotReady = 1'b0;
    idx    = 0;
    budget = 200;
    while (idx < 6 && budget > 0) begin
      applyStimulus(1'b1, 1'b1, six[idx], took);
      if (took) idx++;
      budget--;
    end
    checkValue("six_all_accepted", 8'(idx), 8'd6);
    checkValue("six_ready_dropped", {7'd0, sawNotReady}, 8'd1);
    idleCycles(60);

    $display("[TB] illegal codes 1111, 0011");
    applyStimulus(1'b1, 1'b1, 4'b1111, took);
    applyStimulus(1'b1, 1'b1, 4'b0011, took);
    applyStimulus(1'b1, 1'b0, 4'd0, took);
    checkValue("illegal_cnt", err_cnt, 8'd2);
    idleCycles(3);

    $display("[TB] reset during SHOW with codes queued");
    applyStimulus(1'b1, 1'b1, 4'b1100, took);
    applyStimulus(1'b1, 1'b1, 4'b1010, took);
    applyStimulus(1'b1, 1'b1, 4'b1001, took);
    applyStimulus(1'b0, 1'b1, 4'b1000, took);
    checkValue("abort_key_n", key_n, 8'hFF);
    idleCycles(15);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 64) != 0, 1'($urandom % 2), 4'($urandom % 16), took);
    end
    idleCycles(40);

    $display("[TB] err_cnt saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, ((i % 2) == 0) ? 4'b1111 : 4'b0000, took);
    end
    applyStimulus(1'b1, 1'b0, 4'd0, took);
    checkValue("err_cnt_sat", err_cnt, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
